// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order requests to
// instruction memory over a grant/valid handshake, buffers the returned
// words in a small queue and hands one instruction per cycle to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        stop,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruccion,
    output logic [31:0] pc_next,
    output logic        inst_valid
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_reg, pc_next_val;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;

    logic [31:0]   q_word [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

    logic          redirect;
    logic          fire;
    logic          drop_now;
    logic          push;
    logic          pop;
    logic [CW:0]   credits;

    // Credits in use: every in-flight response already owns a queue slot.
    assign credits  = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign redirect = ena & branch_taken;
    // Request is combinational and withdrawn during reset, redirect or ena=0.
    assign imem_req = rst & ena & ~branch_taken & (credits < QDEPTH_W);
    assign fire     = imem_req & imem_gnt;
    assign drop_now = imem_rvalid & (drop_reg != '0);
    // A word arriving on the redirect edge is lost with the flush.
    assign push     = imem_rvalid & (drop_reg == '0) & ~redirect;
    assign pop      = ena & ~stop & inst_valid & ~branch_taken;

    assign imem_addr   = pc_reg;
    assign inst_valid  = (count_reg != '0);
    assign instruccion = inst_valid ? q_word[rd_ptr_reg] : 32'h0;
    assign pc_next     = inst_valid ? (q_pc[rd_ptr_reg] + 32'd4) : 32'h0;

    // Next-state computation for PC, pointers and the three counters.
    always_comb begin
        pc_next_val      = pc_reg;
        resp_pc_next     = resp_pc_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg + CW'(fire) - CW'(imem_rvalid);
        drop_next        = drop_reg - CW'(drop_now);

        if (redirect) begin
            pc_next_val  = branch_target;
            resp_pc_next = branch_target;
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            count_next   = '0;
            // Words still to be discarded are themselves counted in
            // outstanding, so everything left in flight after this edge
            // is exactly outstanding minus the response consumed now.
            drop_next    = outstanding_reg - CW'(imem_rvalid);
        end else begin
            if (fire) begin
                pc_next_val = pc_reg + 32'd4;
            end
            if (push) begin
                resp_pc_next = resp_pc_reg + 32'd4;
                wr_ptr_next  = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            pc_reg          <= pc_next_val;
            resp_pc_reg     <= resp_pc_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    // Queue storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr_reg] <= imem_rdata;
            q_pc[wr_ptr_reg]   <= resp_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small in-order memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        stop;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruccion;
    logic [31:0] pc_next;
    logic        inst_valid;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic [31:0] pend_addr [$];
    int          pend_rdy  [$];
    logic [31:0] exp_head;
    logic [31:0] q_base;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .stop         (stop),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruccion  (instruccion),
        .pc_next      (pc_next),
        .inst_valid   (inst_valid)
    );

    // One clock cycle: record a grant, cross the edge, present the memory response.
    task automatic tick();
        if (rst && imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_rdy.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            pend_addr.delete();
            pend_rdy.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else if (pend_rdy.size() > 0 && pend_rdy[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] ^ 32'hA5A5_0000;
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; stop = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruccion !== 32'h0 ||
                pc_next !== 32'h0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: req=%b addr=%h instr=%h pc_next=%h valid=%b required 0/0/0/0/0",
                         imem_req, imem_addr, instruccion, pc_next, inst_valid);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        $display("reset released at cycle %0d", cyc);
    endtask

    // 1-cycle memory straight out of reset: request in cycle 1, data in cycle 3.
    task automatic test_stream();
        exp_head = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c - 1))) begin
                n_fail++;
                $display("FAIL stream_req c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, 32'(4 * (c - 1)));
            end
            n_cmp++;
            if (inst_valid !== (c >= 3)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: inst_valid=%b required %b", c, inst_valid, (c >= 3));
            end
            if (inst_valid) begin
                n_cmp++;
                if (instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                    n_fail++;
                    $display("FAIL stream_data c%0d: instr=%h pc_next=%h required %h/%h",
                             c, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
                end
                $display("pop pc=%h instr=%h", exp_head, instruccion);
                exp_head += 32'd4;
            end
            tick();
        end
    endtask

    // Decode stall for 6 cycles: output held, requests stop at 4 credits.
    task automatic test_stall();
        stop = 1'b1;
        #1;
        for (int s = 0; s < 6; s++) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                n_fail++;
                $display("FAIL stall_hold s%0d: valid=%b instr=%h pc_next=%h required 1/%h/%h",
                         s, inst_valid, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
            end
            n_cmp++;
            if (imem_req !== (s < 2)) begin
                n_fail++;
                $display("FAIL stall_req s%0d: imem_req=%b required %b", s, imem_req, (s < 2));
            end
            tick();
        end
        stop = 1'b0;
        #1;
        for (int s = 0; s < 8; s++) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                n_fail++;
                $display("FAIL stall_release s%0d: valid=%b instr=%h pc_next=%h required 1/%h/%h",
                         s, inst_valid, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
            end
            $display("pop pc=%h instr=%h", exp_head, instruccion);
            exp_head += 32'd4;
            tick();
        end
    endtask

    // Redirect with a 3-cycle memory and two requests in flight.
    task automatic test_redirect();
        lat = 3; imem_gnt = 1'b0;
        #1;
        for (int s = 0; s < 8; s++) begin
            if (inst_valid) begin
                n_cmp++;
                if (instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                    n_fail++;
                    $display("FAIL redir_drain s%0d: instr=%h pc_next=%h required %h/%h",
                             s, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
                end
                exp_head += 32'd4;
            end
            tick();
        end
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_addr !== exp_head) begin
            n_fail++;
            $display("FAIL redir_empty: valid=%b addr=%h required 0/%h", inst_valid, imem_addr, exp_head);
        end
        imem_gnt = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== exp_head + 32'd4) begin
            n_fail++;
            $display("FAIL redir_second_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, exp_head + 32'd4);
        end
        tick();
        imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_req_withdrawn: imem_req=%b required 0", imem_req);
        end
        tick();
        branch_taken = 1'b0; imem_gnt = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redir_target_req: req=%b addr=%h required 1/00000100", imem_req, imem_addr);
        end
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_dropped s%0d: inst_valid=%b instr=%h required 0", s, inst_valid, instruccion);
            end
            tick();
        end
        n_cmp++;
        if (inst_valid !== 1'b1 || instruccion !== 32'hA5A5_0100 || pc_next !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL redir_first_target: valid=%b instr=%h pc_next=%h required 1/a5a50100/00000104",
                     inst_valid, instruccion, pc_next);
        end
        exp_head = 32'h0000_0100;
        for (int s = 0; s < 8; s++) begin
            if (inst_valid) begin
                n_cmp++;
                if (instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                    n_fail++;
                    $display("FAIL redir_stream s%0d: instr=%h pc_next=%h required %h/%h",
                             s, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
                end
                $display("pop pc=%h instr=%h", exp_head, instruccion);
                exp_head += 32'd4;
            end
            tick();
        end
    endtask

    // ena=0 with two responses in flight; redirect ignored while disabled.
    task automatic test_ena();
        imem_gnt = 1'b0;
        #1;
        for (int s = 0; s < 10; s++) begin
            if (inst_valid) begin
                n_cmp++;
                if (instruccion !== (exp_head ^ 32'hA5A5_0000)) begin
                    n_fail++;
                    $display("FAIL ena_drain s%0d: instr=%h required %h", s, instruccion, exp_head ^ 32'hA5A5_0000);
                end
                exp_head += 32'd4;
            end
            tick();
        end
        q_base = exp_head;
        imem_gnt = 1'b1;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== q_base) begin
            n_fail++;
            $display("FAIL ena_start: valid=%b req=%b addr=%h required 0/1/%h", inst_valid, imem_req, imem_addr, q_base);
        end
        tick();
        tick();
        ena = 1'b0; imem_gnt = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            if (s == 3) begin
                branch_taken = 1'b1; branch_target = 32'h0000_0300;
                #1;
            end else if (s == 4) begin
                branch_taken = 1'b0;
                #1;
            end
            n_cmp++;
            if (imem_req !== 1'b0 || imem_addr !== q_base + 32'd8) begin
                n_fail++;
                $display("FAIL ena_frozen s%0d: req=%b addr=%h required 0/%h", s, imem_req, imem_addr, q_base + 32'd8);
            end
            n_cmp++;
            if (inst_valid !== (s >= 2) || (s >= 2 && (instruccion !== (q_base ^ 32'hA5A5_0000) ||
                                                      pc_next !== q_base + 32'd4))) begin
                n_fail++;
                $display("FAIL ena_hold s%0d: valid=%b instr=%h pc_next=%h required %b/%h/%h",
                         s, inst_valid, instruccion, pc_next, (s >= 2), q_base ^ 32'hA5A5_0000, q_base + 32'd4);
            end
            tick();
        end
        ena = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || instruccion !== ((q_base + 32'(4 * s)) ^ 32'hA5A5_0000)) begin
                n_fail++;
                $display("FAIL ena_resume s%0d: valid=%b instr=%h required 1/%h",
                         s, inst_valid, instruccion, (q_base + 32'(4 * s)) ^ 32'hA5A5_0000);
            end
            $display("pop pc=%h instr=%h", q_base + 32'(4 * s), instruccion);
            tick();
        end
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_empty: inst_valid=%b required 0", inst_valid);
        end
        exp_head = q_base + 32'd8;
    endtask

    // Mid-stream asynchronous reset, then restart from RESET_PC.
    task automatic test_rst_pulse();
        lat = 1; imem_gnt = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            tick();
        end
        n_cmp++;
        if (inst_valid !== 1'b1 || imem_addr === 32'h0) begin
            n_fail++;
            $display("FAIL rst_prestream: valid=%b addr=%h required 1/nonzero", inst_valid, imem_addr);
        end
        rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend_addr.delete(); pend_rdy.delete();
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruccion !== 32'h0 ||
                pc_next !== 32'h0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_async s%0d: req=%b addr=%h instr=%h pc_next=%h valid=%b required 0/0/0/0/0",
                         s, imem_req, imem_addr, instruccion, pc_next, inst_valid);
            end
            tick();
        end
        rst = 1'b1;
        #1;
    endtask

    // Grant withheld for 3 cycles at pc=0x8 after the restart.
    task automatic test_gnt_hold();
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) imem_gnt = 1'b0;
            if (c == 6) imem_gnt = 1'b1;
            #1;
            if (c >= 3 && c <= 6) begin
                n_cmp++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL gnt_hold_addr c%0d: req=%b addr=%h required 1/00000008", c, imem_req, imem_addr);
                end
            end else if (c <= 2) begin
                n_cmp++;
                if (imem_addr !== 32'(4 * (c - 1))) begin
                    n_fail++;
                    $display("FAIL gnt_restart_addr c%0d: addr=%h required %h", c, imem_addr, 32'(4 * (c - 1)));
                end
            end
            n_cmp++;
            if (inst_valid !== (c == 3 || c == 4 || c == 8)) begin
                n_fail++;
                $display("FAIL gnt_valid c%0d: inst_valid=%b required %b", c, inst_valid, (c == 3 || c == 4 || c == 8));
            end
            if (c == 3 || c == 4 || c == 8) begin
                exp_head = (c == 8) ? 32'h8 : 32'(4 * (c - 3));
                n_cmp++;
                if (instruccion !== (exp_head ^ 32'hA5A5_0000) || pc_next !== exp_head + 32'd4) begin
                    n_fail++;
                    $display("FAIL gnt_data c%0d: instr=%h pc_next=%h required %h/%h",
                             c, instruccion, pc_next, exp_head ^ 32'hA5A5_0000, exp_head + 32'd4);
                end
                $display("pop pc=%h instr=%h", exp_head, instruccion);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ena();
        test_rst_pulse();
        test_gnt_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
